// File: rtl/uart_arb_pkg.sv
// Shared types and default constants for the UART TX arbiter.
package uart_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  localparam int DATA_W_DEF         = 8;
  localparam int TIMEOUT_CYCLES_DEF = 200000;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin select: lowest offset from ptr (with wrap) wins.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   win_idx,
  output logic [NUM_REQ-1:0] win_onehot
);

  int idx;

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    any        = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    idx        = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        any        = 1'b1;
        win_idx    = IDX_W'(idx);
        win_onehot = NUM_REQ'(1) << idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ requesters.
// Optional watchdog enabled by defining UART_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | arbitrating; spurious uart_tx_done ignored
// WAIT  | byte in flight; waiting for uart_tx_done (or watchdog)
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int IDX_W          = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         uart_data,
  output logic                      uart_send,
  input  logic                      uart_tx_done,
  output logic                      busy,
  output logic [IDX_W-1:0]          cur_id,
  output logic                      err
);

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    cur_id_q, cur_id_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                send_q, send_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                err_q, err_d;

  logic                any;
  logic [IDX_W-1:0]    win_idx;
  logic [NUM_REQ-1:0]  win_onehot;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req        (req),
    .ptr        (ptr_q),
    .any        (any),
    .win_idx    (win_idx),
    .win_onehot (win_onehot)
  );

`ifdef UART_ARB_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cur_id_d = cur_id_q;
    data_d   = data_q;
    send_d   = 1'b0;
    gnt_d    = '0;
    done_d   = '0;
    err_d    = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (any) begin
          data_d   = req_data[win_idx*DATA_W +: DATA_W];
          send_d   = 1'b1;
          gnt_d    = win_onehot;
          cur_id_d = win_idx;
          ptr_d    = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
          state_d  = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      WAIT: begin
        // A tx_done coincident with our own send pulse belongs to an older byte.
        if (uart_tx_done && !send_q) begin
          done_d  = NUM_REQ'(1) << cur_id_q;
          state_d = IDLE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cur_id_q <= '0;
      data_q   <= '0;
      send_q   <= 1'b0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cur_id_q <= cur_id_d;
      data_q   <= data_d;
      send_q   <= send_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign uart_data = data_q;
  assign uart_send = send_q;
  assign busy      = (state_q == WAIT);
  assign cur_id    = cur_id_q;
  assign err       = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle vector table plus multi-cycle sequences.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [7:0]  uart_data;
  logic        uart_send;
  logic        uart_tx_done;
  logic        busy;
  logic [1:0]  cur_id;
  logic        err;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .done         (done),
    .uart_data    (uart_data),
    .uart_send    (uart_send),
    .uart_tx_done (uart_tx_done),
    .busy         (busy),
    .cur_id       (cur_id),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] req;
    logic       td;
    logic [3:0] gnt;
    logic [3:0] done;
    logic       send;
    logic       busy;
    logic [1:0] cid;
    logic [7:0] data;
  } vec_t;

  vec_t vt[15];
  logic [7:0] bytes[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic t);
    @(negedge clk);
    req = r;
    uart_tx_done = t;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    uart_tx_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_gnt(input logic [3:0] r, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(r, 1'b0);
      if (gnt != 4'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int exp_id;
    rst = 1'b0;
    req = '0;
    uart_tx_done = 1'b0;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h6A; bytes[3] = 8'h44;
    req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};

    //           req      td    gnt      done     send  busy  cid    data
    vt[0]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00};
    vt[1]  = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 8'h6A};
    vt[2]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 8'h6A};
    vt[3]  = '{4'b0000, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0, 2'd2, 8'h6A};
    vt[4]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 8'h6A};
    vt[5]  = '{4'b1000, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b1, 2'd3, 8'h44};
    vt[6]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3, 8'h44};
    vt[7]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3, 8'h44};
    vt[8]  = '{4'b0101, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b0, 2'd3, 8'h44};
    vt[9]  = '{4'b0101, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0, 8'h11};
    vt[10] = '{4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 8'h11};
    vt[11] = '{4'b0100, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 2'd0, 8'h11};
    vt[12] = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 8'h6A};
    vt[13] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 8'h6A};
    vt[14] = '{4'b0000, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0, 2'd2, 8'h6A};

    do_reset();
    #1;
    chk("reset gnt",  32'(gnt), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    chk("reset send", 32'(uart_send), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset err",  32'(err), 32'h0);
    chk("reset data", 32'(uart_data), 32'h0);

    for (int i = 0; i < 15; i++) begin
      step(vt[i].req, vt[i].td);
      chk($sformatf("v%0d gnt", i),  32'(gnt), 32'(vt[i].gnt));
      chk($sformatf("v%0d done", i), 32'(done), 32'(vt[i].done));
      chk($sformatf("v%0d send", i), 32'(uart_send), 32'(vt[i].send));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vt[i].busy));
      chk($sformatf("v%0d cid", i),  32'(cur_id), 32'(vt[i].cid));
      chk($sformatf("v%0d data", i), 32'(uart_data), 32'(vt[i].data));
    end

    // All four requesting from reset: order 0,1,2,3,0.
    do_reset();
    for (int t = 0; t < 5; t++) begin
      exp_id = t % 4;
      wait_gnt(4'b1111, ok);
      chk($sformatf("rr%0d granted", t), 32'(ok), 32'h1);
      chk($sformatf("rr%0d gnt", t),  32'(gnt), 32'(4'b0001 << exp_id));
      chk($sformatf("rr%0d data", t), 32'(uart_data), 32'(bytes[exp_id]));
      chk($sformatf("rr%0d cid", t),  32'(cur_id), 32'(exp_id));
      step(4'b1111, 1'b0);
      chk($sformatf("rr%0d nosend", t), 32'(uart_send), 32'h0);
      step(4'b1111, 1'b1);
      chk($sformatf("rr%0d done", t), 32'(done), 32'(4'b0001 << exp_id));
      // One idle clock after done before the next grant can appear.
      chk($sformatf("rr%0d idlegap", t), 32'(uart_send), 32'h0);
    end

    // Reset three cycles into WAIT aborts the byte; requester 0 wins next.
    do_reset();
    step(4'b0010, 1'b0);
    chk("mid gnt", 32'(gnt), 32'h2);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    chk("mid busy before", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("mid busy", 32'(busy), 32'h0);
    chk("mid send", 32'(uart_send), 32'h0);
    chk("mid gntz", 32'(gnt), 32'h0);
    chk("mid done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(4'b0000, 1'b1);
    chk("mid nodone", 32'(done), 32'h0);
    step(4'b1111, 1'b0);
    chk("mid req0 wins", 32'(gnt), 32'h1);

    // Withheld tx_done.
    do_reset();
    step(4'b0001, 1'b0);
    chk("to gnt", 32'(gnt), 32'h1);
`ifdef UART_ARB_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      step(4'b0000, 1'b0);
      chk($sformatf("to c%0d err", k), 32'(err), 32'h0);
    end
    step(4'b0000, 1'b0);
    chk("to err pulse", 32'(err), 32'h1);
    chk("to idle", 32'(busy), 32'h0);
    chk("to nodone", 32'(done), 32'h0);
    step(4'b0000, 1'b0);
    chk("to err drop", 32'(err), 32'h0);
    step(4'b0011, 1'b0);
    chk("to ptr kept", 32'(gnt), 32'h2);
`else
    for (int k = 1; k < 40; k++) step(4'b0000, 1'b0);
    chk("to busy held", 32'(busy), 32'h1);
    chk("to err zero", 32'(err), 32'h0);
    chk("to nodone", 32'(done), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
